// File: rtl/key_press_gen_if.sv
// key_press_gen_if: request/response bundle between a press requester (master)
// and the key-press generator (slave).
interface key_press_gen_if #(
  parameter int unsigned HOLD_W = 10
) ();
  logic              req;
  logic [HOLD_W-1:0] hold_len;
  logic              key;
  logic              ready;
  logic              done;
  logic [9:0]        press_cnt;

  modport master (
    output req,
    output hold_len,
    input  key,
    input  ready,
    input  done,
    input  press_cnt
  );

  modport slave (
    input  req,
    input  hold_len,
    output key,
    output ready,
    output done,
    output press_cnt
  );
endinterface

// File: rtl/key_press_gen.sv
// key_press_gen: drives an active-low key waveform (press, hold, release, gap) per request.
// Define KEY_BOUNCE_EN to add LFSR-driven contact bounce windows around the hold.
module key_press_gen #(
  parameter int unsigned HOLD_W     = 10,
  parameter int unsigned BOUNCE_CYC = 8,
  parameter int unsigned GAP_CYC    = 16
) (
  input  logic           clock,
  input  logic           reset,
  key_press_gen_if.slave bus
);

  localparam int unsigned GapW  = $clog2(GAP_CYC + 1);
  localparam int unsigned BncW  = $clog2(BOUNCE_CYC + 1);
  localparam int unsigned CntW0 = (HOLD_W > GapW) ? HOLD_W : GapW;
  localparam int unsigned CntW  = (CntW0 > BncW) ? CntW0 : BncW;

`ifdef KEY_BOUNCE_EN
  typedef enum logic [2:0] {
    StIdle, StPressBounce, StHold, StReleaseBounce, StGap
  } state_e;
`else
  typedef enum logic [1:0] {
    StIdle, StHold, StGap
  } state_e;
`endif

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              key_q, key_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic [9:0]        press_cnt_q, press_cnt_d;
  logic [HOLD_W-1:0] hold_eff;

`ifdef KEY_BOUNCE_EN
  logic [7:0]        lfsr_q, lfsr_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
`endif

  // A zero hold length still produces a one-cycle press.
  assign hold_eff = (bus.hold_len == '0) ? HOLD_W'(1) : bus.hold_len;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    key_d       = key_q;
    ready_d     = ready_q;
    done_d      = 1'b0;
    press_cnt_d = press_cnt_q;
`ifdef KEY_BOUNCE_EN
    hold_d      = hold_q;
    lfsr_d      = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
`endif

    unique case (state_q)
      StIdle: begin
        key_d   = 1'b1;
        ready_d = 1'b1;
        if (bus.req) begin
          ready_d = 1'b0;
          key_d   = 1'b0;
`ifdef KEY_BOUNCE_EN
          hold_d  = hold_eff;
          cnt_d   = CntW'(BOUNCE_CYC - 1);
          state_d = StPressBounce;
`else
          cnt_d   = CntW'(hold_eff) - CntW'(1);
          state_d = StHold;
`endif
        end
      end

`ifdef KEY_BOUNCE_EN
      // cnt_q counts cycles left after the current one; cnt_q==1 means the next is the last.
      StPressBounce: begin
        if (cnt_q == '0) begin
          key_d   = 1'b0;
          cnt_d   = CntW'(hold_q) - CntW'(1);
          state_d = StHold;
        end else begin
          cnt_d = cnt_q - CntW'(1);
          key_d = (cnt_q == CntW'(1)) ? 1'b0 : lfsr_d[0];
        end
      end
`endif

      StHold: begin
        key_d = 1'b0;
        if (cnt_q == '0) begin
          key_d   = 1'b1;
`ifdef KEY_BOUNCE_EN
          cnt_d   = CntW'(BOUNCE_CYC - 1);
          state_d = StReleaseBounce;
`else
          cnt_d   = CntW'(GAP_CYC - 1);
          state_d = StGap;
`endif
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end

`ifdef KEY_BOUNCE_EN
      StReleaseBounce: begin
        if (cnt_q == '0) begin
          key_d   = 1'b1;
          cnt_d   = CntW'(GAP_CYC - 1);
          state_d = StGap;
        end else begin
          cnt_d = cnt_q - CntW'(1);
          key_d = (cnt_q == CntW'(1)) ? 1'b1 : lfsr_d[0];
        end
      end
`endif

      StGap: begin
        key_d = 1'b1;
        if (cnt_q == '0) begin
          ready_d     = 1'b1;
          done_d      = 1'b1;
          press_cnt_d = press_cnt_q + 10'd1;
          state_d     = StIdle;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end

      default: begin
        key_d   = 1'b1;
        ready_d = 1'b1;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      key_q       <= 1'b1;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      press_cnt_q <= '0;
`ifdef KEY_BOUNCE_EN
      lfsr_q      <= 8'hA5;
      hold_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      key_q       <= key_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      press_cnt_q <= press_cnt_d;
`ifdef KEY_BOUNCE_EN
      lfsr_q      <= lfsr_d;
      hold_q      <= hold_d;
`endif
    end
  end

  assign bus.key       = key_q;
  assign bus.ready     = ready_q;
  assign bus.done      = done_q;
  assign bus.press_cnt = press_cnt_q;

endmodule

// File: doc/key_press_gen.md
# key_press_gen

Key-press emulator: the transmit-side counterpart of the pushbutton debounce/one-shot receiver. On a request it drives an active-low key waveform (press, hold, release, recovery gap) onto a key line, optionally with pseudo-random contact bounce. It is used for hands-free auto-press sequencing and for driving the debounce path in-system during bring-up and regression.

## Interface
- HOLD_W, 10: width of the hold-length input and hold counter.
- BOUNCE_CYC, 8: length of each bounce window in cycles, min 2. Used only with KEY_BOUNCE_EN.
- GAP_CYC, 16: released recovery cycles after each press, min 1.
- clock  in  1  sole clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- req  in  1  press request; sampled only while ready=1.
- hold_len  in  HOLD_W  cycles key is held solidly low; sampled with req; 0 treated as 1.
- key  out  1  emulated key, active-low (1 = released).
- ready  out  1  idle, able to accept req.
- done  out  1  one-cycle pulse when a press sequence completes.
- press_cnt  out  10  completed press sequences, modulo 1024.

## Operation
- Reset values: key=1, ready=1, done=0, press_cnt=0, state IDLE, LFSR=8'hA5.
- States: IDLE, PRESS_BOUNCE, HOLD, RELEASE_BOUNCE, GAP.
- IDLE: ready=1, key=1. If req=1 at an edge:
  - latch H = max(hold_len, 1);
  - ready=0 from that edge;
  - go to PRESS_BOUNCE (KEY_BOUNCE_EN) or HOLD.
- PRESS_BOUNCE: BOUNCE_CYC cycles.
  - First and last cycles key=0.
  - Intermediate cycles key = LFSR[0].
- HOLD: key=0 for exactly H cycles.
- RELEASE_BOUNCE: BOUNCE_CYC cycles.
  - First and last cycles key=1.
  - Intermediate cycles key = LFSR[0].
- GAP: key=1 for GAP_CYC cycles, then IDLE.
  - On entering IDLE: done=1 and press_cnt increments (1023 wraps to 0) on the same edge.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, advances every cycle including IDLE, never reaches all-zero.
- req while ready=0: ignored, not queued. hold_len is ignored except on the accept edge.
- Reset asserted mid-sequence: next edge forces key=1, ready=1, state IDLE, press_cnt=0. No done pulse.
- Reset and req on the same edge: reset wins and req is dropped.

## Timing
- All outputs are registered. key changes on the accept edge N; there is no extra pipeline stage.
- Without bounce:
  - key=0 after edges N..N+H-1;
  - key=1 from edge N+H;
  - done=1 and ready=1 after edge N+H+GAP_CYC.
- With bounce:
  - press window after edges N..N+B-1 (B = BOUNCE_CYC);
  - solid low after N+B..N+B+H-1;
  - release window after N+B+H..N+2B+H-1;
  - gap follows; done and ready after edge N+2B+H+GAP_CYC.
- done is high for exactly one cycle, coincident with the first ready=1 cycle.
- Back-to-back: req held high is accepted on the edge where done=1. Successive sequences have no idle bubble beyond GAP_CYC.
- Maximum H = 2^HOLD_W - 1. The hold counter must not wrap within a sequence.

## Configuration
- KEY_BOUNCE_EN defined: the PRESS_BOUNCE and RELEASE_BOUNCE states exist and the LFSR drives the intermediate bounce cycles.
- KEY_BOUNCE_EN undefined: both bounce states and the LFSR are compiled out. The sequence is IDLE→HOLD→GAP→IDLE and the key edges are clean.
- All other behaviour, the ports and the reset values are identical in both builds.

## Test plan
- Clean press, no KEY_BOUNCE_EN, hold_len=5, req at edge 10 → key=0 after edges 10–14; key=1 from edge 15; done/ready after edge 31; press_cnt=1.
- hold_len=0 → key low exactly 1 cycle; done 17 cycles after the accept edge.
- KEY_BOUNCE_EN, hold_len=20, req at edge 0 → key=0 on cycles 0, 7, 8–27; key=1 on cycles 28 and 35; done after edge 52; cycles 1–6 and 29–34 match the reference LFSR model seeded 8'hA5.
- req held high continuously, hold_len=3, no bounce → a new accept every 20 cycles; 1025 sequences wrap press_cnt to 1.
- req pulsed while busy at cycles 2 and 12 of a hold_len=10 sequence → ignored; exactly one done; press_cnt +1.
- reset asserted during HOLD at cycle 4 → key=1 and ready=1 after that edge; no done; press_cnt=0; a req on the following edge is accepted normally.
